// File: rtl/seq_mult_ctrl_if.sv
// Operand/product handshake bundle for seq_mult_ctrl.
// Bit ranges are 1-based: bit 1 is the LSB.
interface seq_mult_ctrl_if #(
   parameter int bw = 16
);
   logic            start;
   logic [bw:1]     A;
   logic [bw:1]     B;
   logic            busy;
   logic            out_valid;
   logic            out_ready;
   logic [2*bw:1]   out;

   modport master (
      output start, A, B, out_ready,
      input  busy, out_valid, out
   );

   modport slave (
      input  start, A, B, out_ready,
      output busy, out_valid, out
   );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Iterative shift-add unsigned multiplier: one 2*bw-bit adder reused over up to bw cycles.
// Optional SEQ_MULT_EARLY_TERM_EN stops as soon as no multiplier bits remain.
module seq_mult_ctrl #(
   parameter int bw = 16
) (
   input  logic           CLK,
   input  logic           RESETn,
   seq_mult_ctrl_if.slave bus
);
   localparam int CW = $clog2(bw);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [bw:1]     mplier_q, mplier_d;
   logic [2*bw:1]   mcand_q, mcand_d;
   logic [2*bw:1]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*bw:1]   addend;
   logic [2*bw:1]   sum;

   // Shared adder; carry-out is dropped because the product always fits.
   assign addend = mplier_q[1] ? mcand_q : '0;
   assign sum    = acc_q + addend;

   always_comb begin
      state_d  = state_q;
      mplier_d = mplier_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mplier_d = bus.A;
               mcand_d  = {{bw{1'b0}}, bus.B};
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            acc_d    = sum;
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(bw - 1)) begin
               state_d = DONE;
            end
`ifdef SEQ_MULT_EARLY_TERM_EN
            else if (mplier_q[bw:2] == '0) begin
               state_d = DONE;
            end
`else
`endif
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q  <= IDLE;
         mplier_q <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mplier_q <= mplier_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   // Status comes straight from registered state so no input reaches an output combinationally.
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out       = acc_q;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl (bw=16): vector table with scoreboard queue
// plus hand-written hold and mid-operation reset sequences.
module tb_seq_mult_ctrl;
   localparam int BW = 16;

   typedef struct {
      logic [BW-1:0]   a;
      logic [BW-1:0]   b;
      logic [2*BW-1:0] p;
   } vec_t;

   logic CLK    = 1'b0;
   logic RESETn = 1'b1;
   logic clk_en = 1'b0;

   int tests  = 0;
   int failed = 0;
   logic [2*BW-1:0] exp_q[$];
   vec_t vecs[7];

   seq_mult_ctrl_if #(.bw(BW)) bus ();

   seq_mult_ctrl #(.bw(BW)) dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .bus    (bus)
   );

   always begin
      #5;
      if (clk_en) CLK = ~CLK;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic int exp_latency(input logic [BW-1:0] a);
      int lat;
`ifdef SEQ_MULT_EARLY_TERM_EN
      lat = 1;
      for (int i = 0; i < BW; i++) if (a[i]) lat = i + 1;
`else
      lat = BW;
`endif
      return lat;
   endfunction

   // Start one operation with out_ready high; check latency, busy, product and return to IDLE.
   task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [2*BW-1:0] p);
      int   n;
      logic busy_ok;
      logic [2*BW-1:0] e;
      @(negedge CLK);
      bus.A = a;
      bus.B = b;
      bus.start = 1'b1;
      bus.out_ready = 1'b1;
      exp_q.push_back(p);
      @(posedge CLK);
      #1 bus.start = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      while (n < 200) begin
         if (!bus.busy) busy_ok = 1'b0;
         @(posedge CLK);
         #1;
         n++;
         if (bus.out_valid) break;
      end
      check("valid_seen", {63'd0, bus.out_valid}, 64'd1);
      check("latency", 64'(n), 64'(exp_latency(a)));
      check("busy_calc", {63'd0, busy_ok & bus.busy}, 64'd1);
      if (exp_q.size() == 0) begin
         check("queue_nonempty", 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         check("product", 64'(bus.out), 64'(e));
      end
      @(posedge CLK);
      #1;
      check("idle_after", {62'd0, bus.busy, bus.out_valid}, 64'd0);
   endtask

   initial begin
      int   n;
      logic hold_ok;
      logic [2*BW-1:0] held;

      vecs[0] = '{16'd3,     16'd5,     32'd15};
      vecs[1] = '{16'hFFFF,  16'hFFFF,  32'hFFFE0001};
      vecs[2] = '{16'd0,     16'h1234,  32'd0};
      vecs[3] = '{16'd7,     16'd9,     32'd63};
      vecs[4] = '{16'd1,     16'd7,     32'd7};
      vecs[5] = '{16'h8000,  16'd2,     32'h00010000};
      vecs[6] = '{16'h1234,  16'h5678,  32'h06260060};

      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.out_ready = 1'b0;

      // Asynchronous reset with the clock stopped
      #2 RESETn = 1'b0;
      #1;
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_out", 64'(bus.out), 64'd0);
      #4 RESETn = 1'b1;
      clk_en = 1'b1;

      for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

      // Hold in DONE with out_ready low while start is pulsed
      @(negedge CLK);
      bus.A = 16'd12;
      bus.B = 16'd11;
      bus.start = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge CLK);
      #1 bus.start = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 200) begin
         @(posedge CLK);
         #1;
         n++;
      end
      check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      held = bus.out;
      check("hold_product", 64'(held), 64'd132);
      hold_ok = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         bus.A = 16'd3;
         bus.B = 16'd3;
         bus.start = 1'b1;
         @(posedge CLK);
         #1;
         if (!bus.out_valid || !bus.busy || bus.out !== held) hold_ok = 1'b0;
      end
      bus.start = 1'b0;
      check("hold_stable", {63'd0, hold_ok}, 64'd1);
      @(negedge CLK);
      bus.out_ready = 1'b1;
      @(posedge CLK);
      #1;
      check("hold_release_idle", {62'd0, bus.busy, bus.out_valid}, 64'd0);
      check("idle_keeps_out", 64'(bus.out), 64'd132);
      run_op(16'd21, 16'd2, 32'd42);

      // Reset in the middle of an operation discards it
      @(negedge CLK);
      bus.A = 16'd100;
      bus.B = 16'd200;
      bus.start = 1'b1;
      @(posedge CLK);
      #1 bus.start = 1'b0;
      for (int c = 0; c < 7; c++) @(posedge CLK);
      #2 RESETn = 1'b0;
      #1;
      check("midrst_busy", {63'd0, bus.busy}, 64'd0);
      check("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
      check("midrst_out", 64'(bus.out), 64'd0);
      @(negedge CLK);
      RESETn = 1'b1;
      run_op(16'd7, 16'd9, 32'd63);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
